// File: rtl/input_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : input_conditioner
//  Purpose  : Two-channel front end for the two-input state machine.
//             Each channel: SYNC_STAGES-flop synchronizer, consecutive-sample
//             debouncer, registered one-cycle rise/fall strobes.
//  Option   : define INPUT_CONDITIONER_GLITCH_CNT_EN to add saturating
//             per-channel counters of aborted (glitch) transitions.
//  Revision : 1.0  initial release
// ============================================================================
module input_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int GLITCH_W        = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in0_raw,
   input  logic                in1_raw,
   output logic                in0,
   output logic                in1,
   output logic                in0_rise,
   output logic                in0_fall,
   output logic                in1_rise,
   output logic                in1_fall
`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
   ,
   output logic [GLITCH_W-1:0] in0_glitch_cnt,
   output logic [GLITCH_W-1:0] in1_glitch_cnt
`endif
);

   localparam int                 c_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [c_CNT_W-1:0] c_DEB   = c_CNT_W'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {
      S_LO      = 2'd0,
      S_PEND_HI = 2'd1,
      S_HI      = 2'd2,
      S_PEND_LO = 2'd3
   } state_t;

   // Reject parameter values the structure cannot honour.
   if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("SYNC_STAGES must be at least 2");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES must be at least 1");
   end
   if (GLITCH_W < 1) begin : g_bad_glitch_w
      $error("GLITCH_W must be at least 1");
   end

   logic [1:0] w_raw;
   logic [1:0] w_out;
   logic [1:0] w_rise;
   logic [1:0] w_fall;
`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
   logic [1:0][GLITCH_W-1:0] w_gcnt;
`endif

   assign w_raw = {in1_raw, in0_raw};

   for (genvar ch = 0; ch < 2; ch++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_sync;
      logic                   w_sync;
      state_t                 r_state;
      state_t                 w_state_nxt;
      logic [c_CNT_W-1:0]     r_cnt;
      logic [c_CNT_W-1:0]     w_cnt_nxt;
      logic [c_CNT_W-1:0]     w_cnt_inc;
      logic                   r_rise;
      logic                   r_fall;
      logic                   w_rise_nxt;
      logic                   w_fall_nxt;

      // Plain flop chain: no logic between stages so metastability can settle.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) r_sync <= '0;
         else     r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[ch]};
      end

      assign w_sync    = r_sync[SYNC_STAGES-1];
      // Count is 0 in the stable states, so this also yields "becomes 1" there.
      assign w_cnt_inc = r_cnt + 1'b1;

      // Debounce state, run counter and edge strobes.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_state <= S_LO;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
         end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
         end
      end

      // Next state: count consecutive samples that disagree with the output.
      always_comb begin
         w_state_nxt = r_state;
         w_cnt_nxt   = '0;
         w_rise_nxt  = 1'b0;
         w_fall_nxt  = 1'b0;
         case (r_state)
            S_LO, S_PEND_HI: begin
               if (w_sync) begin
                  if (w_cnt_inc == c_DEB) begin
                     w_state_nxt = S_HI;
                     w_rise_nxt  = 1'b1;
                  end else begin
                     w_state_nxt = S_PEND_HI;
                     w_cnt_nxt   = w_cnt_inc;
                  end
               end else begin
                  w_state_nxt = S_LO;
               end
            end
            S_HI, S_PEND_LO: begin
               if (!w_sync) begin
                  if (w_cnt_inc == c_DEB) begin
                     w_state_nxt = S_LO;
                     w_fall_nxt  = 1'b1;
                  end else begin
                     w_state_nxt = S_PEND_LO;
                     w_cnt_nxt   = w_cnt_inc;
                  end
               end else begin
                  w_state_nxt = S_HI;
               end
            end
            default: w_state_nxt = S_LO;
         endcase
      end

      assign w_out[ch]  = (r_state == S_HI) || (r_state == S_PEND_LO);
      assign w_rise[ch] = r_rise;
      assign w_fall[ch] = r_fall;

`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
      logic                w_glitch;
      logic [GLITCH_W-1:0] r_gcnt;

      // A pending change that reverts before acceptance is a glitch.
      assign w_glitch = ((r_state == S_PEND_HI) && !w_sync) ||
                        ((r_state == S_PEND_LO) &&  w_sync);

      // Saturating glitch counter.
      always_ff @(posedge clk or posedge rst) begin
         if (rst)                            r_gcnt <= '0;
         else if (w_glitch && (r_gcnt != '1)) r_gcnt <= r_gcnt + 1'b1;
      end

      assign w_gcnt[ch] = r_gcnt;
`endif
   end

   assign in0      = w_out[0];
   assign in1      = w_out[1];
   assign in0_rise = w_rise[0];
   assign in0_fall = w_fall[0];
   assign in1_rise = w_rise[1];
   assign in1_fall = w_fall[1];
`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
   assign in0_glitch_cnt = w_gcnt[0];
   assign in1_glitch_cnt = w_gcnt[1];
`endif

endmodule
`default_nettype wire
